fb_writer: RTL and testbench
============================

# fb_writer

Downstream of the pixel reorder stage (`sort`). Takes the in-order RGB565 pixel stream, buffers it in an internal FIFO, and writes it to external frame memory as fixed-length bursts over a request/acknowledge and valid/ready interface. Maintains a double-buffered frame base: the block toggles buffers at each frame end and reports which buffer is complete, for the display reader.

## Interface
- `BURST`, 16: words per memory burst; power of two.
- `FIFO_DEPTH`, 64: pixel FIFO depth; power of two, ≥ 2*BURST.
- `FRAME_PIX`, 307200: pixels per frame; must be a multiple of BURST.
- `ADDR_W`, 22: memory word-address width.
- `FB0_BASE`, 22'h000000: word base of buffer 0.
- `FB1_BASE`, 22'h080000: word base of buffer 1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pix_data`  in  16  RGB565 pixel, in raster order.
- `pix_valid`  in  1  pixel strobe; no backpressure upstream.
- `wr_req`  out  1  burst request; held until acknowledged.
- `wr_addr`  out  ADDR_W  burst start word address; stable while `wr_req`=1.
- `wr_ack`  in  1  one-cycle acceptance of the request.
- `wr_data`  out  16  burst data word.
- `wr_valid`  out  1  `wr_data` is valid.
- `wr_ready`  in  1  memory accepts the word when `wr_valid`=1.
- `wr_last`  out  1  marks the final word of the burst.
- `frame_done`  out  1  one-cycle pulse after the final burst of a frame.
- `fb_sel`  out  1  buffer currently being written.
- `front_buf`  out  1  last completed buffer; equals ~`fb_sel` after the first frame.
- `overflow`  out  1  sticky flag: a pixel was dropped because the FIFO was full.

## Operation
- FIFO: push on `pix_valid` when not full. If `pix_valid` arrives while the FIFO is full, drop the pixel and set `overflow`. Only reset clears `overflow`. Push and pop in the same cycle are legal, and occupancy stays unchanged.
- FSM has three states: IDLE, REQ, DATA.
  - IDLE → REQ when FIFO count ≥ BURST. Latch `wr_addr` = base(`fb_sel`) + `offset`.
  - REQ: `wr_req`=1. On `wr_ack`, go to DATA. `wr_req` drops in the cycle after `wr_ack`.
  - DATA: `wr_valid`=1 and `wr_data` = FIFO head (show-ahead). Each `wr_valid`&`wr_ready` cycle pops one word and increments the beat counter. `wr_last`=1 on beat BURST-1. Transfer of the last beat → IDLE.
- A burst never starts with fewer than BURST words in the FIFO, so `wr_valid` never deasserts mid-burst.
- `offset` is 20 bits and advances by BURST after each completed burst.
- When `offset`+BURST == FRAME_PIX at burst end:
  - `offset` wraps to 0;
  - `fb_sel` toggles;
  - `front_buf` takes the old `fb_sel`;
  - `frame_done` pulses for one cycle.
- Address arithmetic: base + zero-extended `offset`, modulo 2^ADDR_W.
- Reset values of outputs: `wr_req`, `wr_valid`, `wr_last`, `frame_done`, `overflow`, `fb_sel`, `front_buf` = 0; `wr_addr`, `wr_data` = 0. Internal: FIFO empty, FSM IDLE, `offset` 0, beat counter 0.
- Reset mid-burst: the burst is abandoned and buffered pixels are discarded. After reset release, writing restarts at FB0_BASE.

## Timing
- A push at edge N is counted at N+1. If that makes count ≥ BURST in IDLE, `wr_req` rises at edge N+2.
- `wr_ack` seen at edge M: `wr_req`=0 and `wr_valid`=1 from M+1.
- With `wr_ready` held at 1, the burst takes exactly BURST cycles. The FSM is IDLE the cycle after the last beat, and a new `wr_req` can assert the following cycle.
- `wr_ready`=0 stalls: `wr_data`, `wr_last` and the beat counter hold.
- `frame_done`, the `fb_sel` toggle and the `front_buf` update all occur in the cycle after the last beat of the frame.
- `wr_ack` outside REQ is ignored. `wr_ready` outside DATA is ignored.

## Test plan
- **Single burst:** 16 consecutive pixels 0x0001..0x0010, `wr_ack` one cycle after `wr_req`, `wr_ready`=1 → one request at `wr_addr`=0x000000, data 0x0001..0x0010 in order, `wr_last` on 0x0010, FIFO empty afterwards.
- **Backpressure:** same stimulus with `wr_ready` toggling 1,0,1,0 → identical data order, exactly 16 transfers, `wr_data` held during stall cycles.
- **Frame wrap:** FRAME_PIX=64 override, 128 pixels → `wr_addr` sequence 0x0, 0x10, 0x20, 0x30, then 0x080000...0x080030. `frame_done` pulses twice. `fb_sel` reads 1 then 0; `front_buf` reads 0 then 1.
- **Overflow:** `wr_ack` held low, 65 pixels pushed → `overflow`=1 after the 65th. After acking, 64 words drain; the 65th pixel never appears.
- **Concurrent push/pop:** continuous `pix_valid` during a burst → no dropped pixels, `overflow`=0, back-to-back requests with addresses +16 each.
- **Reset mid-burst:** assert `rst` after 5 beats → all outputs 0 immediately. Following 16 pixels are written at 0x000000.

Source files
------------

// File: rtl/fb_writer.sv
// Pixel FIFO plus burst writer into a double-buffered frame in external memory.
// Each burst pops BURST words from the FIFO; buffers swap at every frame end.
module fb_writer #(
   parameter int unsigned        BURST      = 16,
   parameter int unsigned        FIFO_DEPTH = 64,
   parameter int unsigned        FRAME_PIX  = 307200,
   parameter int unsigned        ADDR_W     = 22,
   parameter logic [ADDR_W-1:0]  FB0_BASE   = 22'h000000,
   parameter logic [ADDR_W-1:0]  FB1_BASE   = 22'h080000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       pix_data,
   input  logic              pix_valid,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_ack,
   output logic [15:0]       wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              wr_last,
   output logic              frame_done,
   output logic              fb_sel,
   output logic              front_buf,
   output logic              overflow
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [PW:0]    Depth    = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]    BurstCnt = (PW+1)'(BURST);
   localparam logic [BW-1:0]  LastBeat = BW'(BURST - 1);
   localparam logic [19:0]    BurstOff = 20'(BURST);
   localparam logic [19:0]    LastOff  = 20'(FRAME_PIX - BURST);

   typedef enum logic [1:0] {StIdle, StReq, StData} state_e;
   state_e r_state, w_state_d;

   logic [15:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr, r_rptr;
   logic [PW:0]       r_count;
   logic [BW-1:0]     r_beat;
   logic [19:0]       r_offset;
   logic [ADDR_W-1:0] r_addr;
   logic              r_fb_sel, r_front, r_frame_done, r_overflow;
   logic              w_full, w_push, w_pop, w_last_beat, w_burst_end, w_frame_end, w_start;

   assign w_full      = (r_count == Depth);
   assign w_push      = pix_valid & ~w_full;
   assign w_pop       = (r_state == StData) & wr_ready;
   assign w_last_beat = (r_beat == LastBeat);
   assign w_burst_end = w_pop & w_last_beat;
   assign w_frame_end = w_burst_end & (r_offset == LastOff);
   assign w_start     = (r_state == StIdle) & (r_count >= BurstCnt);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= pix_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_start)     w_state_d = StReq;
         StReq:   if (wr_ack)      w_state_d = StData;
         StData:  if (w_burst_end) w_state_d = StIdle;
         default:                  w_state_d = StIdle;
      endcase
   end

   // Data is gated outside DATA so wr_data reads zero whenever no burst is active.
   always_comb begin
      wr_req   = 1'b0;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      wr_data  = '0;
      unique case (r_state)
         StReq:  wr_req = 1'b1;
         StData: begin
            wr_valid = 1'b1;
            wr_last  = w_last_beat;
            wr_data  = r_mem[r_rptr];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= '0;
         r_beat       <= '0;
         r_offset     <= '0;
         r_fb_sel     <= 1'b0;
         r_front      <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_start) r_addr <= (r_fb_sel ? FB1_BASE : FB0_BASE) + ADDR_W'(r_offset);
         if (w_pop)   r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
         if (w_burst_end) r_offset <= w_frame_end ? '0 : r_offset + BurstOff;
         r_frame_done <= w_frame_end;
         if (w_frame_end) begin
            r_fb_sel <= ~r_fb_sel;
            r_front  <= r_fb_sel;
         end
         if (pix_valid & w_full) r_overflow <= 1'b1;
      end
   end

   assign wr_addr    = r_addr;
   assign frame_done = r_frame_done;
   assign fb_sel     = r_fb_sel;
   assign front_buf  = r_front;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: bursts, backpressure, frame wrap, overflow, reset mid-burst.
// A small frame (FRAME_PIX=64) keeps buffer swaps within reach.
module tb_fb_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        wr_req;
   logic [21:0] wr_addr;
   logic        wr_ack;
   logic [15:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic        wr_last;
   logic        frame_done, fb_sel, front_buf, overflow;

   logic        ack_en = 1'b0;
   logic        rdy_toggle = 1'b0;
   logic        stalled = 1'b0;
   logic [16:0] held = '0;
   logic [16:0] data_q [$];
   logic [21:0] addr_q [$];
   logic        fsel_q [$];
   logic        front_q [$];
   int          n_vec = 0;
   int          n_miss = 0;

   fb_writer #(
      .BURST      (16),
      .FIFO_DEPTH (64),
      .FRAME_PIX  (64),
      .ADDR_W     (22),
      .FB0_BASE   (22'h000000),
      .FB1_BASE   (22'h080000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_ack     (wr_ack),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_last    (wr_last),
      .frame_done (frame_done),
      .fb_sel     (fb_sel),
      .front_buf  (front_buf),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Memory side: ack one cycle after wr_req, ready either solid or alternating.
   initial begin
      wr_ack   = 1'b0;
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         wr_ack   = ack_en && wr_req && !wr_ack;
         wr_ready = rdy_toggle ? ~wr_ready : 1'b1;
      end
   end

   // Monitor: inputs are stable at the falling edge, so what is seen here transfers next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (wr_req && wr_ack) addr_q.push_back(wr_addr);
            if (stalled && wr_valid) check("stall_hold", {15'd0, wr_last, wr_data}, {15'd0, held});
            if (wr_valid && wr_ready) data_q.push_back({wr_last, wr_data});
            stalled = wr_valid && !wr_ready;
            held    = {wr_last, wr_data};
            if (frame_done) begin
               fsel_q.push_back(fb_sel);
               front_q.push_back(front_buf);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_queues();
      data_q.delete();
      addr_q.delete();
      fsel_q.delete();
      front_q.delete();
   endtask

   task automatic do_reset();
      pix_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_queues();
   endtask

   task automatic push_pixels(input int n, input logic [15:0] start);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         pix_valid = 1'b1;
         pix_data  = start + 16'(i);
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic wait_xfers(input int n, input int budget, input string tag);
      int k = 0;
      while (data_q.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (data_q.size() < n) check(tag, data_q.size(), n);
   endtask

   task automatic check_data(input int n, input logic [15:0] start);
      logic [15:0] exp_d;
      check("xfer_count", data_q.size(), n);
      for (int i = 0; i < n; i++) begin
         exp_d = start + 16'(i);
         check("data", {16'd0, data_q[i][15:0]}, {16'd0, exp_d});
         check("last", {31'd0, data_q[i][16]}, {31'd0, ((i % 16) == 15)});
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_wr_req"},   wr_req,   0);
      check({tag, "_wr_valid"}, wr_valid, 0);
      check({tag, "_wr_last"},  wr_last,  0);
      check({tag, "_wr_data"},  wr_data,  0);
      check({tag, "_wr_addr"},  wr_addr,  0);
      check({tag, "_frame"},    frame_done, 0);
      check({tag, "_fb_sel"},   fb_sel,   0);
      check({tag, "_front"},    front_buf, 0);
      check({tag, "_ovf"},      overflow, 0);
   endtask

   logic [21:0] exp_a;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_queues();

      // Single burst
      ack_en = 1'b1;
      rdy_toggle = 1'b0;
      push_pixels(16, 16'h0001);
      wait_xfers(16, 100, "single_timeout");
      repeat (10) @(negedge clk);
      check_data(16, 16'h0001);
      check("single_nreq", addr_q.size(), 1);
      check("single_addr", addr_q[0], 22'h000000);
      check("single_empty_noreq", wr_req, 0);
      check("single_ovf", overflow, 0);

      // Backpressure; second burst of the frame lands at offset 16
      clear_queues();
      rdy_toggle = 1'b1;
      push_pixels(16, 16'h0001);
      wait_xfers(16, 200, "bp_timeout");
      repeat (10) @(negedge clk);
      check_data(16, 16'h0001);
      check("bp_nreq", addr_q.size(), 1);
      check("bp_addr", addr_q[0], 22'h000010);

      // Frame wrap with continuous push during bursts
      do_reset();
      rdy_toggle = 1'b0;
      push_pixels(128, 16'h4000);
      wait_xfers(128, 400, "wrap_timeout");
      repeat (10) @(negedge clk);
      check_data(128, 16'h4000);
      check("wrap_nreq", addr_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         exp_a = (i < 4) ? 22'(i * 16) : 22'h080000 + 22'((i - 4) * 16);
         check("wrap_addr", addr_q[i], exp_a);
      end
      check("wrap_nframe", fsel_q.size(), 2);
      check("wrap_fsel0", fsel_q[0], 1);
      check("wrap_front0", front_q[0], 0);
      check("wrap_fsel1", fsel_q[1], 0);
      check("wrap_front1", front_q[1], 1);
      check("wrap_ovf", overflow, 0);
      check("wrap_fb_sel_end", fb_sel, 0);
      check("wrap_front_end", front_buf, 1);

      // Overflow: 64 fill the FIFO, the 65th is dropped
      do_reset();
      ack_en = 1'b0;
      push_pixels(64, 16'h0100);
      check("ovf_before", overflow, 0);
      check("ovf_req_held", wr_req, 1);
      push_pixels(1, 16'hDEAD);
      check("ovf_after", overflow, 1);
      ack_en = 1'b1;
      wait_xfers(64, 400, "ovf_timeout");
      repeat (20) @(negedge clk);
      check_data(64, 16'h0100);
      check("ovf_nreq", addr_q.size(), 4);
      for (int i = 0; i < 4; i++) check("ovf_addr", addr_q[i], 22'(i * 16));
      check("ovf_sticky", overflow, 1);
      check("ovf_fb_sel", fb_sel, 1);

      // Reset mid-burst, then restart at FB0_BASE
      do_reset();
      push_pixels(16, 16'h0A00);
      wait_xfers(5, 100, "midrst_timeout");
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_queues();
      push_pixels(16, 16'h0B00);
      wait_xfers(16, 100, "postrst_timeout");
      repeat (10) @(negedge clk);
      check_data(16, 16'h0B00);
      check("postrst_nreq", addr_q.size(), 1);
      check("postrst_addr", addr_q[0], 22'h000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
